fsm_rw_burst_ctrl: RTL and testbench
====================================

// Module: fsm_rw_burst_ctrl
// PURPOSE
//  Parametrised successor of the single-channel read/write FSM controller.
//  - Arbitrates round-robin between NUM_CH request channels.
//  - Runs multi-beat write or read bursts.
//  - Times out stalled beats.
//  - Exposes OVL-style protocol check flags for assertion monitors.
//  - Sits between channel requesters and a shared beat-level data path.
// PARAMETERS
//  NUM_CH     4   number of requesting channels (>=2)
//  BURST_W    4   width of burst_len; burst is burst_len+1 beats (1..2**BURST_W)
//  TIMEOUT    16  max consecutive stalled cycles (beat_valid & !beat_ready) before abort
// PORTS
//  clock       in   1         single clock, all logic on posedge
//  reset       in   1         synchronous, active-high
//  enable      in   1         global run enable
//  wr_req      in   NUM_CH    per-channel write request, level, held until done
//  rd_req      in   NUM_CH    per-channel read request, level, held until done
//  burst_len   in   BURST_W   beats-1, sampled on grant
//  beat_ready  in   1         data path accepts current beat
//  grant       out  NUM_CH    one-hot granted channel, 0 when IDLE
//  grant_wr    out  1         1 = active burst is write, 0 = read
//  beat_valid  out  1         beat offered to data path
//  done        out  1         1-cycle pulse after last beat accepted
//  state       out  3         IDLE=0 WRITE=1 READ=2 DONE=3
//  err_timeout out  1         1-cycle pulse on stall abort
//  fire_collision   out 1     1-cycle pulse: granted ch had wr_req & rd_req at grant
//  fire_req_dropped out 1     1-cycle pulse: granted ch dropped its request mid-burst
// BEHAVIOUR
//  - Reset: state=IDLE; grant=0; grant_wr=0; beat_valid=0; done=0; all err/fire=0.
//    Round-robin pointer last=NUM_CH-1, so ch0 has top priority first.
//  - IDLE: if enable & any (wr_req|rd_req), grant next requesting ch after last (wrap).
//    - Grant registered next cycle; state -> WRITE if wr_req of that ch, else READ.
//    - Write wins if both are set; fire_collision pulses in the grant cycle.
//    - Latch burst_len into beat counter; update last.
//    - enable=0 or no req: remain IDLE.
//  - WRITE/READ: beat_valid=1 while enable=1.
//    - Beat transfers on beat_valid & beat_ready; counter decrements.
//    - Transfer at counter==0 -> DONE.
//    - enable=0 mid-burst: beat_valid=0, counter and stall timer frozen, state held.
//      Resume on enable=1.
//  - Stall timer: counts cycles with beat_valid & !beat_ready; cleared on any transfer.
//    - Reaching TIMEOUT: err_timeout pulse, state -> IDLE, grant cleared, no done.
//  - fire_req_dropped: granted ch's active-direction req low in WRITE/READ before last beat.
//    Pulses each such cycle; burst still completes (flag only).
//  - DONE: done=1 for exactly one cycle, grant held; next cycle -> IDLE, grant=0.
//    - Minimum request-to-request spacing: grant, N beats, DONE, IDLE.
//  - Latency: req in IDLE -> grant/beat_valid 1 cycle later.
//    - Last transfer -> done 1 cycle later.
//  - Single-beat burst (burst_len=0): one transfer, then DONE.
//  - Reset mid-burst: immediate return to reset values next edge; no done, no error pulse.
// TESTING
//  1 reset=1 3 cycles, then wr_req=4'b0001, burst_len=0, beat_ready=1
//    -> grant=0001, grant_wr=1, 1 beat, done 1 cycle later, IDLE.
//  2 wr_req=0011 held, burst_len=2, beat_ready=1
//    -> ch0 then ch1 each 3 beats; done pulses twice; grant order 0001,0010.
//  3 ch2 wr_req=1 & rd_req=1 -> fire_collision=1 in grant cycle, WRITE burst runs.
//  4 READ burst_len=3, beat_ready=0 for 16 cycles
//    -> err_timeout pulse at 16th stall, state=IDLE, done never asserted.
//  5 enable=0 for 5 cycles mid-burst
//    -> beat_valid=0, counter frozen, no timeout; burst resumes, total beats = burst_len+1.
//  6 rd_req of granted ch dropped after beat 1 of 4
//    -> fire_req_dropped pulses; burst completes; done asserted.

Source files
------------

// File: rtl/fsm_rw_burst_ctrl.sv
// Round-robin multi-channel read/write burst controller with stall timeout
// and protocol-check pulse flags for assertion monitors.
module fsm_rw_burst_ctrl #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  wr_req,
  input  logic [NUM_CH-1:0]  rd_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               beat_ready,
  output logic [NUM_CH-1:0]  grant,
  output logic               grant_wr,
  output logic               beat_valid,
  output logic               done,
  output logic [2:0]         state,
  output logic               err_timeout,
  output logic               fire_collision,
  output logic               fire_req_dropped
);

  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t             st;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   next_idx;
  logic               found;
  logic [NUM_CH-1:0]  any_req;
  logic [BURST_W-1:0] beat_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               busy;
  logic               xfer;
  logic               stall;
  logic               act_req;
  logic               last_beat;

  assign state     = st;
  assign any_req   = wr_req | rd_req;
  assign busy      = (st == S_WRITE) || (st == S_READ);
  // beat_valid follows enable combinationally so a paused burst offers no beat
  // in the very cycle enable drops; the handshake then matches the frozen counter.
  assign beat_valid = busy & enable;
  assign xfer       = beat_valid & beat_ready;
  assign stall      = beat_valid & ~beat_ready;
  assign last_beat  = xfer && (beat_cnt == '0);
  // While busy, 'last' holds the granted channel index.
  assign act_req    = grant_wr ? wr_req[last] : rd_req[last];

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!found && any_req[IDX_W'((32'(last) + i) % NUM_CH)]) begin
        found    = 1'b1;
        next_idx = IDX_W'((32'(last) + i) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st               <= S_IDLE;
      grant            <= '0;
      grant_wr         <= 1'b0;
      last             <= IDX_W'(NUM_CH - 1);
      beat_cnt         <= '0;
      stall_cnt        <= '0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      fire_collision   <= 1'b0;
      fire_req_dropped <= 1'b0;
    end else begin
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      fire_collision   <= 1'b0;
      fire_req_dropped <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (enable && found) begin
            grant          <= NUM_CH'(1) << next_idx;
            grant_wr       <= wr_req[next_idx];
            last           <= next_idx;
            beat_cnt       <= burst_len;
            stall_cnt      <= '0;
            fire_collision <= wr_req[next_idx] & rd_req[next_idx];
            st             <= wr_req[next_idx] ? S_WRITE : S_READ;
          end
        end
        S_WRITE, S_READ: begin
          if (!act_req && !last_beat) fire_req_dropped <= 1'b1;
          if (xfer) begin
            stall_cnt <= '0;
            if (beat_cnt == '0) begin
              st   <= S_DONE;
              done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end else if (stall) begin
            if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              st          <= S_IDLE;
              grant       <= '0;
              grant_wr    <= 1'b0;
              stall_cnt   <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          st       <= S_IDLE;
          grant    <= '0;
          grant_wr <= 1'b0;
        end
        default: begin
          st       <= S_IDLE;
          grant    <= '0;
          grant_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_rw_burst_ctrl.sv
// Directed bench for fsm_rw_burst_ctrl: arbitration order, burst lengths,
// timeout, enable pause, collision and dropped-request flags, mid-burst reset.
module tb_fsm_rw_burst_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] wr_req;
  logic [3:0] rd_req;
  logic [3:0] burst_len;
  logic       beat_ready;
  logic [3:0] grant;
  logic       grant_wr;
  logic       beat_valid;
  logic       done;
  logic [2:0] state;
  logic       err_timeout;
  logic       fire_collision;
  logic       fire_req_dropped;

  int total;
  int bad;
  int beats;
  int dones;
  int b0;
  int d0;

  fsm_rw_burst_ctrl #(.NUM_CH(4), .BURST_W(4), .TIMEOUT(16)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .burst_len(burst_len),
    .beat_ready(beat_ready),
    .grant(grant),
    .grant_wr(grant_wr),
    .beat_valid(beat_valid),
    .done(done),
    .state(state),
    .err_timeout(err_timeout),
    .fire_collision(fire_collision),
    .fire_req_dropped(fire_req_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1ns after posedge, so negedge sees the handshake of the coming edge.
  initial begin
    beats = 0;
    dones = 0;
  end
  always @(negedge clock) begin
    if (!reset && beat_valid && beat_ready) beats = beats + 1;
    if (done) dones = dones + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; wr_req = 4'b1111; rd_req = 4'b1111;
    burst_len = 4'd0; beat_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
    total++; if (grant_wr !== 1'b0) begin bad++; $display("FAIL rst_grant_wr got=%b want=0", grant_wr); end
    total++; if (beat_valid !== 1'b0) begin bad++; $display("FAIL rst_beat_valid got=%b want=0", beat_valid); end
    total++; if ({done, err_timeout, fire_collision, fire_req_dropped} !== 4'b0000) begin
      bad++; $display("FAIL rst_pulses got=%b want=0000", {done, err_timeout, fire_collision, fire_req_dropped});
    end
    wr_req = 4'b0000; rd_req = 4'b0000;
  endtask

  task automatic test_single_beat();
    reset = 1'b0; wr_req = 4'b0001; burst_len = 4'd0; beat_ready = 1'b1;
    b0 = beats; d0 = dones;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL sb_grant got=%b want=0001", grant); end
    total++; if (grant_wr !== 1'b1) begin bad++; $display("FAIL sb_grant_wr got=%b want=1", grant_wr); end
    total++; if (state !== 3'd1 || beat_valid !== 1'b1) begin
      bad++; $display("FAIL sb_active got state=%0d valid=%b want state=1 valid=1", state, beat_valid);
    end
    tick();
    total++; if (state !== 3'd3 || done !== 1'b1 || grant !== 4'b0001) begin
      bad++; $display("FAIL sb_done got state=%0d done=%b grant=%b want 3 1 0001", state, done, grant);
    end
    wr_req = 4'b0000;
    tick();
    total++; if (state !== 3'd0 || done !== 1'b0 || grant !== 4'b0000) begin
      bad++; $display("FAIL sb_idle got state=%0d done=%b grant=%b want 0 0 0000", state, done, grant);
    end
    total++; if (beats - b0 != 1) begin bad++; $display("FAIL sb_beats got=%0d want=1", beats - b0); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); reset = 1'b0;
    wr_req = 4'b0011; burst_len = 4'd2; beat_ready = 1'b1;
    b0 = beats; d0 = dones;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rr_first got=%b want=0001", grant); end
    tick(); tick();
    total++; if (state !== 3'd1 || done !== 1'b0) begin
      bad++; $display("FAIL rr_mid got state=%0d done=%b want 1 0", state, done);
    end
    tick();
    total++; if (done !== 1'b1 || grant !== 4'b0001) begin
      bad++; $display("FAIL rr_done0 got done=%b grant=%b want 1 0001", done, grant);
    end
    tick();
    total++; if (state !== 3'd0 || grant !== 4'b0000) begin
      bad++; $display("FAIL rr_gap got state=%0d grant=%b want 0 0000", state, grant);
    end
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rr_second got=%b want=0010", grant); end
    tick(); tick(); tick();
    total++; if (done !== 1'b1 || grant !== 4'b0010) begin
      bad++; $display("FAIL rr_done1 got done=%b grant=%b want 1 0010", done, grant);
    end
    wr_req = 4'b0000;
    tick();
    total++; if (beats - b0 != 6 || dones - d0 != 2) begin
      bad++; $display("FAIL rr_counts got beats=%0d dones=%0d want 6 2", beats - b0, dones - d0);
    end
  endtask

  task automatic test_collision();
    wr_req = 4'b0100; rd_req = 4'b0100; burst_len = 4'd1; beat_ready = 1'b1;
    tick();
    total++; if (fire_collision !== 1'b1 || grant !== 4'b0100 || grant_wr !== 1'b1 || state !== 3'd1) begin
      bad++; $display("FAIL col_grant got fc=%b grant=%b wr=%b state=%0d want 1 0100 1 1",
                      fire_collision, grant, grant_wr, state);
    end
    tick();
    total++; if (fire_collision !== 1'b0) begin bad++; $display("FAIL col_pulse got=%b want=0", fire_collision); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL col_done got=%b want=1", done); end
    wr_req = 4'b0000; rd_req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    rd_req = 4'b1000; burst_len = 4'd3; beat_ready = 1'b0;
    d0 = dones;
    tick();
    total++; if (grant !== 4'b1000 || grant_wr !== 1'b0 || state !== 3'd2) begin
      bad++; $display("FAIL to_grant got grant=%b wr=%b state=%0d want 1000 0 2", grant, grant_wr, state);
    end
    for (int i = 0; i < 15; i++) tick();
    total++; if (state !== 3'd2 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL to_15 got state=%0d err=%b want 2 0", state, err_timeout);
    end
    tick();
    total++; if (err_timeout !== 1'b1 || state !== 3'd0 || grant !== 4'b0000) begin
      bad++; $display("FAIL to_16 got err=%b state=%0d grant=%b want 1 0 0000", err_timeout, state, grant);
    end
    rd_req = 4'b0000;
    tick();
    total++; if (err_timeout !== 1'b0 || dones - d0 != 0) begin
      bad++; $display("FAIL to_after got err=%b dones=%0d want 0 0", err_timeout, dones - d0);
    end
  endtask

  task automatic test_enable_pause();
    wr_req = 4'b0001; burst_len = 4'd3; beat_ready = 1'b1;
    b0 = beats;
    tick();
    tick();
    enable = 1'b0; beat_ready = 1'b0;
    #1;
    total++; if (beat_valid !== 1'b0) begin bad++; $display("FAIL en_valid got=%b want=0", beat_valid); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (state !== 3'd1 || err_timeout !== 1'b0 || beat_valid !== 1'b0) begin
      bad++; $display("FAIL en_hold got state=%0d err=%b valid=%b want 1 0 0", state, err_timeout, beat_valid);
    end
    enable = 1'b1; beat_ready = 1'b1;
    tick(); tick();
    total++; if (state !== 3'd1 || done !== 1'b0) begin
      bad++; $display("FAIL en_resume got state=%0d done=%b want 1 0", state, done);
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL en_done got=%b want=1", done); end
    wr_req = 4'b0000;
    tick();
    total++; if (beats - b0 != 4) begin bad++; $display("FAIL en_beats got=%0d want=4", beats - b0); end
  endtask

  task automatic test_req_dropped();
    rd_req = 4'b0010; burst_len = 4'd3; beat_ready = 1'b1;
    tick();
    total++; if (grant !== 4'b0010 || state !== 3'd2) begin
      bad++; $display("FAIL rd_grant got grant=%b state=%0d want 0010 2", grant, state);
    end
    tick();
    total++; if (fire_req_dropped !== 1'b0) begin bad++; $display("FAIL rd_before got=%b want=0", fire_req_dropped); end
    rd_req = 4'b0000;
    tick();
    total++; if (fire_req_dropped !== 1'b1) begin bad++; $display("FAIL rd_pulse1 got=%b want=1", fire_req_dropped); end
    tick();
    total++; if (fire_req_dropped !== 1'b1) begin bad++; $display("FAIL rd_pulse2 got=%b want=1", fire_req_dropped); end
    tick();
    total++; if (done !== 1'b1 || fire_req_dropped !== 1'b0) begin
      bad++; $display("FAIL rd_done got done=%b frd=%b want 1 0", done, fire_req_dropped);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    wr_req = 4'b0100; burst_len = 4'd5; beat_ready = 1'b1;
    d0 = dones;
    tick(); tick();
    reset = 1'b1;
    tick();
    total++; if (state !== 3'd0 || grant !== 4'b0000 || beat_valid !== 1'b0 ||
                 done !== 1'b0 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL mr_state got state=%0d grant=%b valid=%b done=%b err=%b want 0 0000 0 0 0",
                      state, grant, beat_valid, done, err_timeout);
    end
    reset = 1'b0; wr_req = 4'b0000;
    tick();
    total++; if (dones - d0 != 0 || state !== 3'd0) begin
      bad++; $display("FAIL mr_after got dones=%0d state=%0d want 0 0", dones - d0, state);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_collision();
    test_timeout();
    test_enable_pause();
    test_req_dropped();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
